// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_TAIL,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  localparam logic [1:0] LEN_1B = 2'b00;
  localparam logic [1:0] LEN_2B = 2'b01;

  // Index of the final byte of an access; both 4-byte encodings map to lane 3.
  function automatic logic [1:0] len_to_last(input logic [1:0] len);
    case (len)
      LEN_1B:  return 2'd0;
      LEN_2B:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: picks byte k of a store word and inserts a read byte into lane k.
module mem_byte_lane
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] wr_word_i,
  input  logic [1:0]  wr_lane_i,
  output logic [7:0]  wr_byte_o,
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  rd_lane_i,
  input  logic [7:0]  rd_byte_i,
  output logic [31:0] rd_word_o
);

  always_comb begin
    wr_byte_o = wr_word_i[BYTE_W*wr_lane_i +: BYTE_W];
    rd_word_o = rd_word_i;
    rd_word_o[BYTE_W*rd_lane_i +: BYTE_W] = rd_byte_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store,
// serialising 1/2/4-byte accesses into little-endian byte cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic [XLEN-1:0]   if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              stall_rq_if_o,
  output logic              stall_rq_mem_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   if_data_q, if_data_d;
  logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [7:0]        wr_byte;
  logic [XLEN-1:0]   rd_word;
  logic [1:0]        cap_lane;
  logic              if_abort;
  logic              addr_hi_unused;

  // RAM data lags the address by one cycle, so ACCESS captures the previous lane.
  assign cap_lane = (state_q == ST_TAIL) ? k_q : k_q - 2'd1;
  assign if_abort = (owner_q == OWN_IF) && if_flush_i;
  assign addr_hi_unused = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  mem_byte_lane u_lane (
    .wr_word_i (wdata_q),
    .wr_lane_i (k_q + 2'd1),
    .wr_byte_o (wr_byte),
    .rd_word_i (rdata_q),
    .rd_lane_i (cap_lane),
    .rd_byte_i (ram_din_i),
    .rd_word_o (rd_word)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    k_d         = k_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          state_d    = ST_ACCESS;
          owner_d    = OWN_MEM;
          last_d     = len_to_last(mem_len_i);
          k_d        = 2'd0;
          we_d       = mem_we_i;
          wdata_d    = mem_wdata_i;
          rdata_d    = '0;
          ram_a_d    = mem_addr_i[ADDR_W-1:0];
          ram_wr_d   = mem_we_i;
          ram_dout_d = mem_we_i ? mem_wdata_i[7:0] : 8'h00;
        end else if (if_req_i && !if_flush_i) begin
          state_d    = ST_ACCESS;
          owner_d    = OWN_IF;
          last_d     = 2'd3;
          k_d        = 2'd0;
          we_d       = 1'b0;
          wdata_d    = '0;
          rdata_d    = '0;
          ram_a_d    = if_addr_i[ADDR_W-1:0];
          ram_wr_d   = 1'b0;
          ram_dout_d = 8'h00;
        end
      end

      ST_ACCESS: begin
        if (k_q != 2'd0) rdata_d = rd_word;
        if (if_abort) begin
          state_d  = ST_IDLE;
          ram_wr_d = 1'b0;
        end else if (k_q != last_q) begin
          k_d        = k_q + 2'd1;
          ram_a_d    = ram_a_q + ADDR_W'(1);
          ram_dout_d = we_q ? wr_byte : 8'h00;
        end else if (we_q) begin
          state_d    = ST_DONE;
          ram_wr_d   = 1'b0;
          ram_dout_d = 8'h00;
          mem_done_d = (owner_q == OWN_MEM);
          if_done_d  = (owner_q == OWN_IF);
        end else begin
          state_d = ST_TAIL;
        end
      end

      ST_TAIL: begin
        if (if_abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          rdata_d = rd_word;
          if (owner_q == OWN_IF) begin
            if_data_d = rd_word;
            if_done_d = 1'b1;
          end else begin
            mem_rdata_d = rd_word;
            mem_done_d  = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= 2'd0;
      k_q         <= 2'd0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      k_q         <= k_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // A redirect landing on the IF done cycle squashes the pulse.
  assign if_done_o      = if_done_q & ~if_flush_i;
  assign if_data_o      = if_data_q;
  assign mem_done_o     = mem_done_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign ram_a_o        = ram_a_q;
  assign ram_wr_o       = ram_wr_q;
  assign ram_dout_o     = ram_dout_q;
  assign stall_rq_if_o  = if_req_i & ~if_done_o & ~if_flush_i;
  assign stall_rq_mem_o = mem_req_i & ~mem_done_o;

endmodule
